// File: rtl/snake_stream_checker.sv
// rtl/snake_stream_checker.sv - frame rebuild and collision/eat checker for the snake write stream
//
// Purpose: taps the snake/food cell-write stream, buffers one frame of snake
// segments (tail first, head last, terminated by the food write), then walks
// the buffer one entry per cycle to detect head-on-body collision and
// head-on-food, and reports the result with a one-cycle frame_done strobe.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   wr_en                write strobe, one cell write per cycle when high
//   wr_x, wr_y           cell column / row of the write
//   wr_data              2'b10 snake segment, 2'b01 food (frame end), others ignored
//   frame_done           one-cycle pulse, result outputs updated in this cycle
//   seg_count            segments captured (saturates at MAX_SEG)
//   head_x, head_y       coordinate of the last captured segment
//   collision            head equals an earlier segment of the frame
//   eat                  head equals the food coordinate
//   overflow             more than MAX_SEG segment writes arrived, extras dropped
//   sync_lost            one-cycle pulse when a write is discarded during CHECK/REPORT

module snake_stream_checker #(
  parameter int MAX_SEG = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_x,
  input  logic [3:0]       wr_y,
  input  logic [1:0]       wr_data,
  output logic             frame_done,
  output logic [CNT_W-1:0] seg_count,
  output logic [3:0]       head_x,
  output logic [3:0]       head_y,
  output logic             collision,
  output logic             eat,
  output logic             overflow,
  output logic             sync_lost
);

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [7:0]       r_buf [MAX_SEG];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;
  logic [7:0]       r_food;
  logic             r_col;
  logic             r_eat;
  logic             r_ovf;
  logic             r_drop;

  logic             w_snake;
  logic             w_food;
  logic             w_valid;
  logic             w_full;
  logic             w_idx_last;
  logic             w_report;
  logic             w_sync_lost;
  logic [CNT_W-1:0] w_last;
  logic [7:0]       w_head;

  assign w_snake    = wr_en & (wr_data == 2'b10);
  assign w_food     = wr_en & (wr_data == 2'b01);
  assign w_valid    = w_snake | w_food;
  assign w_full     = (r_count == CNT_W'(MAX_SEG));
  // Head is the newest buffered segment; only meaningful while r_count > 0.
  assign w_last     = r_count - CNT_W'(1);
  assign w_head     = r_buf[w_last];
  assign w_idx_last = (r_idx == w_last);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_SYNC: begin
        if (w_food) w_next_state = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_food) w_next_state = (r_count == '0) ? S_REPORT : S_CHECK;
      end
      S_CHECK: begin
        if (w_idx_last) w_next_state = S_REPORT;
      end
      S_REPORT: begin
        // A write landing in the report cycle itself also breaks sync.
        w_next_state = (r_drop | w_valid) ? S_SYNC : S_COLLECT;
      end
      default: w_next_state = S_SYNC;
    endcase
  end

  // Output decode
  always_comb begin
    w_report    = (r_state == S_REPORT);
    w_sync_lost = w_valid & ((r_state == S_CHECK) | (r_state == S_REPORT));
  end

  // Segment buffer; contents are don't-care outside [0, r_count).
  always_ff @(posedge clk) begin
    if (r_state == S_COLLECT && w_snake && !w_full) begin
      r_buf[r_count] <= {wr_y, wr_x};
    end
  end

  // Frame bookkeeping and registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_food     <= '0;
      r_col      <= 1'b0;
      r_eat      <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop     <= 1'b0;
      frame_done <= 1'b0;
      sync_lost  <= 1'b0;
      seg_count  <= '0;
      head_x     <= '0;
      head_y     <= '0;
      collision  <= 1'b0;
      eat        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= w_report;
      sync_lost  <= w_sync_lost;
      if (w_sync_lost) r_drop <= 1'b1;

      unique case (r_state)
        S_SYNC: begin
          if (w_food) begin
            r_count <= '0;
            r_idx   <= '0;
            r_col   <= 1'b0;
            r_eat   <= 1'b0;
            r_ovf   <= 1'b0;
            r_drop  <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (w_snake) begin
            if (!w_full) r_count <= r_count + CNT_W'(1);
            else         r_ovf   <= 1'b1;
          end
          if (w_food) begin
            r_food <= {wr_y, wr_x};
            r_idx  <= '0;
          end
        end
        S_CHECK: begin
          // Body entries first, the final step compares the head with food.
          if (!w_idx_last) begin
            if (r_buf[r_idx] == w_head) r_col <= 1'b1;
            r_idx <= r_idx + CNT_W'(1);
          end else if (w_head == r_food) begin
            r_eat <= 1'b1;
          end
        end
        S_REPORT: begin
          seg_count <= r_count;
          head_x    <= (r_count == '0) ? 4'd0 : w_head[3:0];
          head_y    <= (r_count == '0) ? 4'd0 : w_head[7:4];
          collision <= r_col;
          eat       <= r_eat;
          overflow  <= r_ovf;
          r_count   <= '0;
          r_idx     <= '0;
          r_col     <= 1'b0;
          r_eat     <= 1'b0;
          r_ovf     <= 1'b0;
          r_drop    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_stream_checker.sv
// tb/tb_snake_stream_checker.sv - self-checking bench for snake_stream_checker

module tb_snake_stream_checker;

  localparam int MAX_SEG = 10;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [3:0]       wr_x;
  logic [3:0]       wr_y;
  logic [1:0]       wr_data;
  logic             frame_done;
  logic [CNT_W-1:0] seg_count;
  logic [3:0]       head_x;
  logic [3:0]       head_y;
  logic             collision;
  logic             eat;
  logic             overflow;
  logic             sync_lost;

  int checks   = 0;
  int failures = 0;

  logic [7:0] frame_q[$];

  snake_stream_checker #(.MAX_SEG(MAX_SEG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .frame_done(frame_done), .seg_count(seg_count),
    .head_x(head_x), .head_y(head_y), .collision(collision), .eat(eat),
    .overflow(overflow), .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wr_en = 1'b0; wr_data = 2'b00; wr_x = 4'd0; wr_y = 4'd0;
  endtask

  task automatic put(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_data = d;
  endtask

  // Segments in frame_q, optionally salted with ignored writes and idle gaps.
  task automatic send_segs(input bit junk);
    foreach (frame_q[i]) begin
      if (junk && $urandom_range(0, 3) == 0)
        put(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
      if (junk && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        idle();
      end
      put(frame_q[i][3:0], frame_q[i][7:4], 2'b10);
    end
  endtask

  // Sends the food write and checks latency and results against a model
  // computed straight from frame_q. hold_writes snake writes are driven on
  // the cycles right after the food write.
  task automatic expect_frame(input string name, input logic [3:0] fx, input logic [3:0] fy,
                              input bit rpt, input int hold_writes);
    int         n, cnt, seen, pulses, lost_bad;
    logic [7:0] head;
    bit         col, et, ovf;
    n    = frame_q.size();
    cnt  = (n > MAX_SEG) ? MAX_SEG : n;
    head = (cnt > 0) ? frame_q[cnt-1] : 8'h00;
    col  = 1'b0;
    for (int j = 0; j < cnt - 1; j++) if (frame_q[j] == head) col = 1'b1;
    et   = (cnt > 0) && (head == {fy, fx});
    ovf  = (n > MAX_SEG);

    put(fx, fy, 2'b01);
    seen = -1; pulses = 0; lost_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        pulses++;
        if (seen < 0) seen = k;
      end
      if (k >= 2 && k <= hold_writes + 1) begin
        if (sync_lost !== 1'b1) lost_bad++;
      end else if (sync_lost !== 1'b0) begin
        lost_bad++;
      end
      if (k <= hold_writes) begin
        wr_en = 1'b1; wr_data = 2'b10;
        wr_x = 4'($urandom_range(0, 15)); wr_y = 4'($urandom_range(0, 15));
      end else begin
        idle();
      end
    end

    checks++;
    if (lost_bad != 0) begin
      failures++;
      $display("FAIL %s sync_lost: bad cycles=%0d expected 0", name, lost_bad);
    end
    checks++;
    if (seen != (rpt ? cnt + 2 : -1)) begin
      failures++;
      $display("FAIL %s latency: frame_done at negedge %0d expected %0d", name, seen, rpt ? cnt + 2 : -1);
    end
    if (rpt) begin
      checks++;
      if (pulses != 1) begin
        failures++;
        $display("FAIL %s pulse_width: got %0d expected 1", name, pulses);
      end
      checks++;
      if (seg_count !== CNT_W'(cnt)) begin
        failures++;
        $display("FAIL %s seg_count: got %0d expected %0d", name, seg_count, cnt);
      end
      checks++;
      if (head_x !== head[3:0] || head_y !== head[7:4]) begin
        failures++;
        $display("FAIL %s head: got x%0d y%0d expected x%0d y%0d", name, head_x, head_y, head[3:0], head[7:4]);
      end
      checks++;
      if (collision !== col) begin
        failures++;
        $display("FAIL %s collision: got %b expected %b", name, collision, col);
      end
      checks++;
      if (eat !== et) begin
        failures++;
        $display("FAIL %s eat: got %b expected %b", name, eat, et);
      end
      checks++;
      if (overflow !== ovf) begin
        failures++;
        $display("FAIL %s overflow: got %b expected %b", name, overflow, ovf);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({frame_done, seg_count, head_x, head_y, collision, eat, overflow, sync_lost} !== '0) begin
      failures++;
      $display("FAIL %s outputs: got fd=%b cnt=%0d hx=%0d hy=%0d col=%b eat=%b ovf=%b sl=%b expected all 0",
               name, frame_done, seg_count, head_x, head_y, collision, eat, overflow, sync_lost);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic seg(input logic [3:0] x, input logic [3:0] y);
    frame_q.push_back({y, x});
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_outputs_zero("reset");
  endtask

  task automatic test_sync_basic();
    frame_q = {};
    expect_frame("first_food", 4'd3, 4'd3, 1'b0, 0);
    frame_q = {}; seg(1, 1); seg(2, 1); seg(3, 1);
    send_segs(1'b0);
    expect_frame("basic", 4'd3, 4'd3, 1'b1, 0);
  endtask

  task automatic test_collision();
    frame_q = {}; seg(2, 2); seg(3, 2); seg(3, 3); seg(2, 3); seg(2, 2);
    send_segs(1'b0);
    expect_frame("collision", 4'd5, 4'd5, 1'b1, 0);
  endtask

  task automatic test_eat();
    frame_q = {}; seg(4, 1); seg(5, 1);
    send_segs(1'b0);
    expect_frame("eat_hit", 4'd5, 4'd1, 1'b1, 0);
    send_segs(1'b0);
    expect_frame("eat_miss", 4'd6, 4'd1, 1'b1, 0);
  endtask

  task automatic test_overflow();
    frame_q = {};
    for (int i = 0; i < 12; i++) seg(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    send_segs(1'b0);
    expect_frame("overflow", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 0);
  endtask

  task automatic test_drop_resync();
    frame_q = {}; seg(1, 7); seg(2, 7); seg(3, 7); seg(4, 7);
    send_segs(1'b0);
    expect_frame("drop", 4'd4, 4'd7, 1'b1, 4);
    frame_q = {}; seg(9, 9); seg(10, 9);
    send_segs(1'b0);
    expect_frame("drop_skipped", 4'd10, 4'd9, 1'b0, 0);
    frame_q = {}; seg(0, 0); seg(15, 15); seg(14, 15);
    send_segs(1'b0);
    expect_frame("drop_after", 4'd14, 4'd15, 1'b1, 0);
  endtask

  task automatic test_empty();
    frame_q = {};
    expect_frame("empty", 4'd8, 4'd8, 1'b1, 0);
  endtask

  task automatic test_reset_mid_check();
    int fd_seen;
    frame_q = {};
    for (int i = 0; i < 6; i++) seg(4'(i), 4'd12);
    send_segs(1'b0);
    put(4'd1, 4'd1, 2'b01);
    @(negedge clk);
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fd_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) fd_seen++;
    end
    checks++;
    if (fd_seen != 0) begin
      failures++;
      $display("FAIL reset_mid_check frame_done: got %0d pulses expected 0", fd_seen);
    end
    check_outputs_zero("reset_mid_check");
    frame_q = {}; seg(3, 3); seg(4, 3);
    send_segs(1'b0);
    expect_frame("post_reset_sync", 4'd4, 4'd3, 1'b0, 0);
    send_segs(1'b0);
    expect_frame("post_reset_report", 4'd4, 4'd3, 1'b1, 0);
  endtask

  task automatic test_random_frames();
    int len;
    for (int f = 0; f < 30; f++) begin
      frame_q = {};
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) seg(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      send_segs(1'b1);
      expect_frame($sformatf("random%0d", f), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'b1, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_sync_basic();
    test_collision();
    test_eat();
    test_overflow();
    test_empty();
    test_drop_resync();
    test_random_frames();
    test_reset_mid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
